// File: rtl/psum_writeback_pkg.sv
// ----------------------------------------------------------------------------
// psum_writeback_pkg
//   Shared definitions for the partial-sum writeback block:
//   - default lane width, lanes per word and SRAM address width
//   - FSM state encoding used by psum_writeback
// Optional feature macro used by the block: PSUM_WB_RELU_EN
// ----------------------------------------------------------------------------
package psum_writeback_pkg;

  localparam int PSUM_BW = 16;
  localparam int COL     = 8;
  localparam int ADDR_W  = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } wb_state_t;

endpackage

// File: rtl/psum_relu.sv
// ----------------------------------------------------------------------------
// psum_relu
//   Single-lane ReLU on a two's-complement value: negative inputs become 0,
//   non-negative inputs pass through unchanged. Purely combinational.
// Ports:
//   lane_in   input  bw  signed lane value
//   lane_out  output bw  rectified lane value
// ----------------------------------------------------------------------------
module psum_relu #(
  parameter int bw = 16
) (
  input  logic [bw-1:0] lane_in,
  output logic [bw-1:0] lane_out
);

  assign lane_out = lane_in[bw-1] ? '0 : lane_in;

endmodule

// File: rtl/psum_writeback.sv
// ----------------------------------------------------------------------------
// psum_writeback
//   Drains num_words words from the output FIFO into the psum SRAM starting
//   at base_addr. One pop per cycle when the FIFO has data; each pop turns
//   into one registered SRAM write in the following cycle. The address
//   pointer wraps modulo 2^addr_w.
//
// Configuration:
//   PSUM_WB_RELU_EN  when defined, every lane is rectified (negative -> 0)
//                    before being written. Latency and handshake unchanged.
//
// Ports:
//   clk          input   1              rising-edge clock
//   reset        input   1              asynchronous active-high reset
//   start        input   1              drain request, honoured in IDLE only
//   base_addr    input   addr_w         first SRAM address
//   num_words    input   addr_w+1       words to drain (0..2^addr_w)
//   ofifo_valid  input   1              output FIFO not empty
//   psum_in      input   psum_bw*col    output FIFO head word
//   ofifo_rd     output  1              pop strobe (combinational)
//   sram_cen     output  1              SRAM chip enable, active-low
//   sram_wen     output  1              SRAM write enable, active-low
//   sram_addr    output  addr_w         SRAM write address
//   sram_d       output  psum_bw*col    SRAM write data
//   busy         output  1              high in DRAIN and FLUSH
//   done         output  1              one-cycle completion pulse
// ----------------------------------------------------------------------------
module psum_writeback
  import psum_writeback_pkg::*;
#(
  parameter int psum_bw = PSUM_BW,
  parameter int col     = COL,
  parameter int addr_w  = ADDR_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [addr_w-1:0]      base_addr,
  input  logic [addr_w:0]        num_words,
  input  logic                   ofifo_valid,
  input  logic [psum_bw*col-1:0] psum_in,
  output logic                   ofifo_rd,
  output logic                   sram_cen,
  output logic                   sram_wen,
  output logic [addr_w-1:0]      sram_addr,
  output logic [psum_bw*col-1:0] sram_d,
  output logic                   busy,
  output logic                   done
);

  localparam int W = psum_bw * col;

  localparam logic [addr_w-1:0] PTR_ONE = {{(addr_w-1){1'b0}}, 1'b1};
  localparam logic [addr_w:0]   REM_ONE = {{addr_w{1'b0}}, 1'b1};

  wb_state_t         state;
  logic [addr_w-1:0] pointer;
  logic [addr_w:0]   remaining;
  logic              pop;
  logic [W-1:0]      wr_word;

  // A pop only happens while draining with words still owed; the remaining
  // test keeps the last pop from being repeated in the FLUSH transition cycle.
  assign pop      = (state == ST_DRAIN) && ofifo_valid && (remaining != '0);
  assign ofifo_rd = pop;

`ifdef PSUM_WB_RELU_EN
  genvar gi;
  generate
    for (gi = 0; gi < col; gi++) begin : g_relu
      psum_relu #(
        .bw(psum_bw)
      ) u_relu (
        .lane_in (psum_in[gi*psum_bw +: psum_bw]),
        .lane_out(wr_word[gi*psum_bw +: psum_bw])
      );
    end
  endgenerate
`else
  assign wr_word = psum_in;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      pointer   <= '0;
      remaining <= '0;
      sram_cen  <= 1'b1;
      sram_wen  <= 1'b1;
      sram_addr <= '0;
      sram_d    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      // Idle SRAM port by default; address and data keep their last values.
      sram_cen <= 1'b1;
      sram_wen <= 1'b1;
      done     <= 1'b0;

      if (pop) begin
        sram_cen  <= 1'b0;
        sram_wen  <= 1'b0;
        sram_addr <= pointer;
        sram_d    <= wr_word;
        pointer   <= pointer + PTR_ONE;
        remaining <= remaining - REM_ONE;
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            pointer   <= base_addr;
            remaining <= num_words;
            if (num_words == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_DRAIN;
              busy  <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (pop && (remaining == REM_ONE)) begin
            state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          // The final write is on the SRAM port during this cycle.
          state <= ST_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psum_writeback.sv
// ----------------------------------------------------------------------------
// tb_psum_writeback
//   Directed bench for psum_writeback: basic drain, stall, address wrap,
//   zero length, reset mid-drain and lane rectification. Inputs change 1ns
//   after the rising edge; outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_psum_writeback;
  import psum_writeback_pkg::*;

  localparam int BW = 16;
  localparam int NC = 8;
  localparam int AW = 11;
  localparam int W  = BW * NC;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   num_words;
  logic          ofifo_valid;
  logic [W-1:0]  psum_in;
  logic          ofifo_rd;
  logic          sram_cen;
  logic          sram_wen;
  logic [AW-1:0] sram_addr;
  logic [W-1:0]  sram_d;
  logic          busy;
  logic          done;

  psum_writeback #(
    .psum_bw(BW),
    .col    (NC),
    .addr_w (AW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .num_words  (num_words),
    .ofifo_valid(ofifo_valid),
    .psum_in    (psum_in),
    .ofifo_rd   (ofifo_rd),
    .sram_cen   (sram_cen),
    .sram_wen   (sram_wen),
    .sram_addr  (sram_addr),
    .sram_d     (sram_d),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Transaction log filled by the per-cycle sampler.
  logic [AW-1:0] wr_addr_q[$];
  logic [W-1:0]  wr_data_q[$];
  logic          wr_wen_q[$];
  int            wr_cyc_q[$];
  logic [W-1:0]  pop_data_q[$];
  int            pop_cyc_q[$];
  int            done_cyc_q[$];
  int            busy_hi     = 0;
  int            cyc         = 0;
  int            head        = 0;
  bit            pop_pending = 1'b0;
  bit            use_custom  = 1'b0;
  logic [W-1:0]  custom_word;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // FIFO word number h: lane i = {h[6:0] as high byte, i+1} (always non-negative).
  function automatic logic [W-1:0] word_of(input int h);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < NC; i++) begin
      w[i*BW +: BW] = 16'(((h % 128) * 256) + i + 1);
    end
    return w;
  endfunction

  // One clock cycle: drive inputs after the edge, sample at the falling edge.
  task automatic cycle(input logic st, input logic vld);
    @(posedge clk);
    #1;
    if (pop_pending) head++;
    start       = st;
    ofifo_valid = vld;
    psum_in     = use_custom ? custom_word : word_of(head);
    @(negedge clk);
    cyc++;
    pop_pending = ofifo_rd;
    if (ofifo_rd) begin
      pop_data_q.push_back(psum_in);
      pop_cyc_q.push_back(cyc);
    end
    if (!sram_cen) begin
      wr_addr_q.push_back(sram_addr);
      wr_data_q.push_back(sram_d);
      wr_wen_q.push_back(sram_wen);
      wr_cyc_q.push_back(cyc);
      $display("[TB] cyc %0d write addr=%h data=%h", cyc, sram_addr, sram_d);
    end
    if (done) done_cyc_q.push_back(cyc);
    if (busy) busy_hi++;
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_wen_q.delete();
    wr_cyc_q.delete();
    pop_data_q.delete();
    pop_cyc_q.delete();
    done_cyc_q.delete();
    busy_hi = 0;
  endtask

  // Checks a completed drain of n words from base; start_cyc is the sample
  // cycle in which start was presented.
  task automatic verify(input string name, input int n, input logic [AW-1:0] base, input int start_cyc);
    int            m;
    logic [AW-1:0] ea;
    check({name, " writes"}, W'(wr_addr_q.size()), W'(n));
    check({name, " pops"},   W'(pop_data_q.size()), W'(n));
    check({name, " dones"},  W'(done_cyc_q.size()), W'(1));
    m = n;
    if (wr_addr_q.size() < m) m = wr_addr_q.size();
    if (pop_data_q.size() < m) m = pop_data_q.size();
    for (int k = 0; k < m; k++) begin
      ea = base + AW'(k);
      check($sformatf("%s addr%0d", name, k), W'(wr_addr_q[k]), W'(ea));
      check($sformatf("%s data%0d", name, k), wr_data_q[k], pop_data_q[k]);
      check($sformatf("%s wen%0d", name, k), W'(wr_wen_q[k]), W'(1'b0));
      check($sformatf("%s lat%0d", name, k), W'(wr_cyc_q[k]), W'(pop_cyc_q[k] + 1));
    end
    if (done_cyc_q.size() > 0) begin
      if (n > 0 && wr_cyc_q.size() > 0)
        check({name, " done_cyc"}, W'(done_cyc_q[0]), W'(wr_cyc_q[wr_cyc_q.size()-1] + 1));
      else
        check({name, " done_cyc"}, W'(done_cyc_q[0]), W'(start_cyc + 1));
    end
    check({name, " busy_end"}, W'(busy), W'(1'b0));
  endtask

  // Start a drain with ofifo_valid held high for the whole run.
  task automatic run_drain(input string name, input logic [AW-1:0] base, input logic [AW:0] n, input int extra);
    int sc;
    clear_log();
    base_addr = base;
    num_words = n;
    cycle(1'b1, 1'b1);
    sc = cyc;
    repeat (extra) cycle(1'b0, 1'b1);
    verify(name, int'(n), base, sc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected $finish)");
    $fatal(1);
  end

  logic [W-1:0] relu_exp;
  int           sc_stall;

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    base_addr   = '0;
    num_words   = '0;
    ofifo_valid = 1'b0;
    psum_in     = '0;
    custom_word = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst cen",  W'(sram_cen),  W'(1'b1));
    check("rst wen",  W'(sram_wen),  W'(1'b1));
    check("rst addr", W'(sram_addr), W'(0));
    check("rst d",    sram_d,        W'(0));
    check("rst busy", W'(busy),      W'(1'b0));
    check("rst done", W'(done),      W'(1'b0));
    check("rst rd",   W'(ofifo_rd),  W'(1'b0));

    // Basic drain, 1 word/cycle; busy spans 3 DRAIN cycles + 1 FLUSH cycle.
    run_drain("basic", 11'h010, 12'd3, 8);
    check("basic busy_cycles", W'(busy_hi), W'(4));

    // Stall pattern 1,0,0,1,1 after start; a second start with other
    // parameters is raised mid-drain and must be ignored.
    clear_log();
    base_addr = 11'h020;
    num_words = 12'd3;
    cycle(1'b1, 1'b1);
    sc_stall = cyc;
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    base_addr = 11'h300;
    num_words = 12'd7;
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    repeat (6) cycle(1'b0, 1'b0);
    verify("stall", 3, 11'h020, sc_stall);

    // Address wrap
    run_drain("wrap", 11'h7FF, 12'd2, 6);

    // Zero length: done one cycle after start, no pop, no write.
    run_drain("zero", 11'h123, 12'd0, 4);

    // Reset after 2 of 5 pops have been consumed.
    clear_log();
    base_addr = 11'h100;
    num_words = 12'd5;
    cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("mid state", W'(dut.state),     W'(ST_IDLE));
    check("mid ptr",   W'(dut.pointer),   W'(0));
    check("mid rem",   W'(dut.remaining), W'(0));
    check("mid cen",   W'(sram_cen),      W'(1'b1));
    check("mid wen",   W'(sram_wen),      W'(1'b1));
    check("mid addr",  W'(sram_addr),     W'(0));
    check("mid d",     sram_d,            W'(0));
    check("mid busy",  W'(busy),          W'(1'b0));
    check("mid done",  W'(done),          W'(1'b0));
    check("mid rd",    W'(ofifo_rd),      W'(1'b0));
    @(posedge clk);
    #1 reset = 1'b0;
    pop_pending = 1'b0;
    run_drain("post_rst", 11'h200, 12'd2, 6);

    // Lane rectification: lanes FFF6, 0005, 8000, 7FFF, then 0001.
    custom_word = '0;
    custom_word[0*BW +: BW] = 16'hFFF6;
    custom_word[1*BW +: BW] = 16'h0005;
    custom_word[2*BW +: BW] = 16'h8000;
    custom_word[3*BW +: BW] = 16'h7FFF;
    for (int i = 4; i < NC; i++) custom_word[i*BW +: BW] = 16'h0001;
`ifdef PSUM_WB_RELU_EN
    relu_exp = custom_word;
    relu_exp[0*BW +: BW] = 16'h0000;
    relu_exp[2*BW +: BW] = 16'h0000;
`else
    relu_exp = custom_word;
`endif
    use_custom = 1'b1;
    clear_log();
    base_addr = 11'h055;
    num_words = 12'd1;
    cycle(1'b1, 1'b1);
    repeat (5) cycle(1'b0, 1'b1);
    use_custom = 1'b0;
    check("relu writes", W'(wr_data_q.size()), W'(1));
    if (wr_data_q.size() > 0) begin
      check("relu data", wr_data_q[0], relu_exp);
      check("relu addr", W'(wr_addr_q[0]), W'(11'h055));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
